// File: rtl/uart_key_injector.sv
// -----------------------------------------------------------------------------
// uart_key_injector
//   Replays ASCII bytes from a UART receiver as one-hot push-button pulses on a
//   20-bit bus. That bus is ORed into the keypad inputs, so the lock box can be
//   driven from a serial terminal. A small FIFO holds typed-ahead key codes.
//   Each key is held for HOLD cycles and then released for GAP cycles, which is
//   long enough for the downstream 2-stage strobe synchroniser to fire once.
//
// Ports
//   clk       in   1    system clock
//   rst       in   1    asynchronous reset, active-low
//   rxdata    in   8    received ASCII byte, valid while rxready=1
//   rxready   in   1    UART has a byte available
//   rxclk     out  1    one-cycle acknowledge that consumes the UART byte
//   pb_out    out  20   one-hot injected key (all-zero when idle)
//   busy      out  1    FSM not idle or FIFO not empty
//   bad_char  out  1    sticky flag: an unmapped byte was received
//   count     out  CW   FIFO occupancy (0..DEPTH)
// -----------------------------------------------------------------------------
module uart_key_injector #(
  parameter int HOLD  = 4,
  parameter int GAP   = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 rxdata,
  input  logic                       rxready,
  output logic                       rxclk,
  output logic [19:0]                pb_out,
  output logic                       busy,
  output logic                       bad_char,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESS   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  // Map an ASCII byte to {valid, key code}; unmapped bytes return valid=0.
  function automatic logic [5:0] decode_key(input logic [7:0] ch);
    logic [5:0] res;
    res = 6'd0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      res = {1'b1, 5'(ch - 8'h30)};        // '0'-'9' -> 0-9
    end else if (ch >= 8'h41 && ch <= 8'h46) begin
      res = {1'b1, 5'(ch - 8'h37)};        // 'A'-'F' -> 10-15
    end else if (ch >= 8'h61 && ch <= 8'h66) begin
      res = {1'b1, 5'(ch - 8'h57)};        // 'a'-'f' -> 10-15
    end else if (ch >= 8'h57 && ch <= 8'h5A) begin
      res = {1'b1, 5'(ch - 8'h47)};        // 'W'-'Z' -> 16-19
    end else if (ch >= 8'h77 && ch <= 8'h7A) begin
      res = {1'b1, 5'(ch - 8'h67)};        // 'w'-'z' -> 16-19
    end else begin
      res = 6'd0;
    end
    return res;
  endfunction

  state_t          r_state, w_state_nx;
  logic [15:0]     r_tmr, w_tmr_nx;
  logic [19:0]     r_pb, w_pb_nx;
  logic [CW-1:0]   r_count, w_count_nx;
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [4:0]      r_mem [DEPTH];
  logic            r_rxclk, r_busy, r_bad;

  logic [5:0]      w_dec;
  logic [4:0]      w_head;
  logic            w_accept, w_push, w_pop, w_have, w_busy_nx;

  // Full is judged on the registered count, so a pop in the same edge never
  // makes room; the cycle showing the ack never accepts a second time.
  assign w_accept   = rxready & ~r_rxclk & (r_count < CW'(DEPTH));
  assign w_dec      = decode_key(rxdata);
  assign w_push     = w_accept & w_dec[5];
  // Registered count means a push into an empty FIFO is only poppable one edge later.
  assign w_have     = (r_count != CW'(0));
  assign w_head     = r_mem[r_rptr];
  assign w_count_nx = r_count + CW'(w_push) - CW'(w_pop);
  assign w_busy_nx  = (w_state_nx != S_IDLE) || (w_count_nx != CW'(0));

  assign rxclk    = r_rxclk;
  assign pb_out   = r_pb;
  assign busy     = r_busy;
  assign bad_char = r_bad;
  assign count    = r_count;

  // Key sequencer: next state, timer, pulse value and FIFO pop request.
  always_comb begin
    w_state_nx = r_state;
    w_tmr_nx   = r_tmr;
    w_pb_nx    = r_pb;
    w_pop      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_have) begin
          w_pop      = 1'b1;
          w_pb_nx    = 20'd1 << w_head;
          w_tmr_nx   = 16'(HOLD - 1);
          w_state_nx = S_PRESS;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_PRESS: begin
        if (r_tmr == 16'd0) begin
          w_pb_nx    = 20'd0;
          w_tmr_nx   = 16'(GAP - 1);
          w_state_nx = S_RELEASE;
        end else begin
          w_tmr_nx   = r_tmr - 16'd1;
        end
      end
      S_RELEASE: begin
        if (r_tmr == 16'd0) begin
          // Chain straight into the next key so bursts have no idle cycle.
          if (w_have) begin
            w_pop      = 1'b1;
            w_pb_nx    = 20'd1 << w_head;
            w_tmr_nx   = 16'(HOLD - 1);
            w_state_nx = S_PRESS;
          end else begin
            w_state_nx = S_IDLE;
          end
        end else begin
          w_tmr_nx   = r_tmr - 16'd1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_pb_nx    = 20'd0;
        w_tmr_nx   = 16'd0;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Output, timer, FIFO pointer/occupancy and error flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmr   <= 16'd0;
      r_pb    <= 20'd0;
      r_count <= CW'(0);
      r_wptr  <= AW'(0);
      r_rptr  <= AW'(0);
      r_rxclk <= 1'b0;
      r_busy  <= 1'b0;
      r_bad   <= 1'b0;
    end else begin
      r_tmr   <= w_tmr_nx;
      r_pb    <= w_pb_nx;
      r_count <= w_count_nx;
      r_rxclk <= w_accept;
      r_busy  <= w_busy_nx;
      if (w_accept && !w_dec[5]) begin
        r_bad <= 1'b1;
      end else begin
        r_bad <= r_bad;
      end
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end else begin
        r_wptr <= r_wptr;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end else begin
        r_rptr <= r_rptr;
      end
    end
  end

  // FIFO storage: contents need no reset, the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_dec[4:0];
    end
  end

endmodule

// File: tb/tb_uart_key_injector.sv
module tb_uart_key_injector;

  localparam int HOLD  = 4;
  localparam int GAP   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rxdata;
  logic        rxready;
  logic        rxclk;
  logic [19:0] pb_out;
  logic        busy;
  logic        bad_char;
  logic [2:0]  count;

  always #5 clk = ~clk;

  uart_key_injector #(.HOLD(HOLD), .GAP(GAP), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rxdata(rxdata), .rxready(rxready), .rxclk(rxclk),
    .pb_out(pb_out), .busy(busy), .bad_char(bad_char), .count(count)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: key slots, not states ----------------
  int          m_q[$];      // queued key codes
  int          m_phase;     // -1 idle, else cycle index in the HOLD+GAP slot
  int          m_code;
  bit          m_rxclk;
  bit          m_bad;

  // Key number = position in the keypad legend (case-insensitive), -1 if none.
  function automatic int key_of(input logic [7:0] ch);
    string legend;
    logic [7:0] u;
    legend = "0123456789ABCDEFWXYZ";
    u = ch;
    if (u >= 8'h61 && u <= 8'h7A) u = u - 8'd32;
    for (int i = 0; i < 20; i++) if (legend[i] == u) return i;
    return -1;
  endfunction

  function automatic int idx_of(input logic [19:0] v);
    for (int i = 0; i < 20; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_phase = -1;
    m_code  = 0;
    m_rxclk = 1'b0;
    m_bad   = 1'b0;
  endtask

  task automatic model_step();
    bit acc, pop;
    int k;
    acc = rxready && !m_rxclk && (m_q.size() < DEPTH);
    pop = (m_phase == -1 || m_phase == HOLD + GAP - 1) && (m_q.size() > 0);
    if (pop) begin
      m_code  = m_q.pop_front();
      m_phase = 0;
    end else if (m_phase == HOLD + GAP - 1) begin
      m_phase = -1;
    end else if (m_phase >= 0) begin
      m_phase++;
    end
    if (acc) begin
      k = key_of(rxdata);
      if (k < 0) m_bad = 1'b1;
      else m_q.push_back(k);
    end
    m_rxclk = acc;
  endtask

  // ---------------- UART emulator and observation ----------------
  logic [7:0] u_q[$];
  int  exp_keys[$];
  int  got_keys[$];
  int  got_len[$];
  int  got_start[$];
  int  cyc = 0;
  int  on_len = 0;
  int  cur_key = 0;
  int  max_count = 0;
  bit  rnd_mode = 1'b0;

  task automatic clear_obs();
    exp_keys.delete();
    got_keys.delete();
    got_len.delete();
    got_start.delete();
    on_len = 0;
  endtask

  task automatic send(input logic [7:0] ch);
    int k;
    u_q.push_back(ch);
    k = key_of(ch);
    if (k >= 0) exp_keys.push_back(k);
    rxready = 1'b1;
    rxdata  = u_q[0];
  endtask

  task automatic tick();
    logic [25:0] exp_v;
    logic [19:0] m_pb;
    string pool;
    pool = "0123456789abcdefABCDEFwxyzWXYZ";
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    m_pb  = (m_phase >= 0 && m_phase < HOLD) ? (20'd1 << m_code) : 20'd0;
    exp_v = {m_pb, 3'(m_q.size()), (m_phase != -1 || m_q.size() > 0), m_bad, m_rxclk};
    chk("cycle{pb,count,busy,bad,rxclk}", {6'd0, pb_out, count, busy, bad_char, rxclk}, {6'd0, exp_v});
    if (pb_out != 20'd0) begin
      if (on_len == 0) begin
        got_start.push_back(cyc);
        cur_key = idx_of(pb_out);
      end
      on_len++;
    end else if (on_len > 0) begin
      got_keys.push_back(cur_key);
      got_len.push_back(on_len);
      on_len = 0;
    end
    if (int'(count) > max_count) max_count = int'(count);
    if (rxclk && u_q.size() > 0) void'(u_q.pop_front());
    if (rnd_mode && u_q.size() == 0 && $urandom_range(0, 2) == 0) begin
      if ($urandom_range(0, 1) == 1) send(pool[$urandom_range(0, pool.len() - 1)]);
      else send(8'($urandom_range(0, 255)));
    end
    rxready = (u_q.size() > 0);
    rxdata  = (u_q.size() > 0) ? u_q[0] : 8'h00;
  endtask

  task automatic run_idle(input int max_cycles);
    int n;
    n = 0;
    while ((u_q.size() > 0 || m_phase != -1 || m_q.size() > 0 || m_rxclk) && n < max_cycles) begin
      tick();
      n++;
    end
    chk("drain_within_budget", (n < max_cycles), 1);
  endtask

  task automatic check_keys(input string name);
    chk({name, "_nkeys"}, got_keys.size(), exp_keys.size());
    for (int i = 0; i < got_keys.size() && i < exp_keys.size(); i++) begin
      chk({name, "_key"}, got_keys[i], exp_keys[i]);
      chk({name, "_hold"}, got_len[i], HOLD);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    u_q.delete();
    rxready = 1'b0;
    rxdata  = 8'h00;
    model_reset();
    clear_obs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic [7:0]  ch;
    logic [19:0] pb;
    logic        bad;
  } vec_t;

  vec_t vt[18];

  initial begin
    vt[0]  = '{8'h35, 20'h00020, 1'b0};  // '5'
    vt[1]  = '{8'h30, 20'h00001, 1'b0};  // '0'
    vt[2]  = '{8'h39, 20'h00200, 1'b0};  // '9'
    vt[3]  = '{8'h41, 20'h00400, 1'b0};  // 'A'
    vt[4]  = '{8'h66, 20'h08000, 1'b0};  // 'f'
    vt[5]  = '{8'h46, 20'h08000, 1'b0};  // 'F'
    vt[6]  = '{8'h57, 20'h10000, 1'b0};  // 'W'
    vt[7]  = '{8'h78, 20'h20000, 1'b0};  // 'x'
    vt[8]  = '{8'h79, 20'h40000, 1'b0};  // 'y'
    vt[9]  = '{8'h5A, 20'h80000, 1'b0};  // 'Z'
    vt[10] = '{8'h2F, 20'h00000, 1'b1};  // '/'
    vt[11] = '{8'h3A, 20'h00000, 1'b1};  // ':'
    vt[12] = '{8'h40, 20'h00000, 1'b1};  // '@'
    vt[13] = '{8'h47, 20'h00000, 1'b1};  // 'G'
    vt[14] = '{8'h60, 20'h00000, 1'b1};  // '`'
    vt[15] = '{8'h67, 20'h00000, 1'b1};  // 'g'
    vt[16] = '{8'h5B, 20'h00000, 1'b1};  // '['
    vt[17] = '{8'h7B, 20'h00000, 1'b1};  // '{'

    rst = 1'b0;
    rxready = 1'b0;
    rxdata = 8'h00;
    model_reset();
    clear_obs();
    repeat (2) @(negedge clk);
    chk("reset_pb", pb_out, 0);
    chk("reset_rxclk", rxclk, 0);
    chk("reset_busy", busy, 0);
    chk("reset_bad", bad_char, 0);
    chk("reset_count", count, 0);
    rst = 1'b1;

    // single-key decode table
    for (int i = 0; i < 18; i++) begin
      logic [19:0] seen;
      clear_obs();
      send(vt[i].ch);
      run_idle(100);
      seen = (got_keys.size() > 0) ? (20'd1 << got_keys[got_keys.size() - 1]) : 20'd0;
      chk("table_pb", seen, vt[i].pb);
      chk("table_npulses", got_keys.size(), (vt[i].pb != 20'd0) ? 1 : 0);
      chk("table_bad", bad_char, vt[i].bad);
      chk("table_busy_low", busy, 0);
      if (got_len.size() > 0) chk("table_hold", got_len[0], HOLD);
    end

    // burst "12AW": back-to-back slots, no idle gap
    do_reset();
    send(8'h31); send(8'h32); send(8'h41); send(8'h57);
    run_idle(200);
    check_keys("burst");
    chk("burst_n", got_keys.size(), 4);
    for (int i = 1; i < got_start.size(); i++)
      chk("burst_spacing", got_start[i] - got_start[i - 1], HOLD + GAP);

    // FIFO fill while busy: 1 key playing plus 6 offered
    clear_obs();
    max_count = 0;
    send(8'h30);
    repeat (3) tick();
    send(8'h33); send(8'h34); send(8'h35); send(8'h36); send(8'h37); send(8'h42);
    run_idle(300);
    check_keys("full");
    chk("full_max_count", max_count, DEPTH);

    // unmapped '?' then 'x'
    do_reset();
    chk("qx_bad_before", bad_char, 0);
    send(8'h3F); send(8'h78);
    run_idle(100);
    chk("qx_bad_after", bad_char, 1);
    chk("qx_n", got_keys.size(), 1);
    if (got_keys.size() > 0) chk("qx_key", got_keys[0], 17);

    // reset in the middle of a press with three keys queued
    do_reset();
    send(8'h31); send(8'h32); send(8'h33); send(8'h34); send(8'h35);
    begin
      int n;
      n = 0;
      while (!(m_phase >= 0 && m_phase < HOLD && m_q.size() == 3) && n < 100) begin
        tick();
        n++;
      end
      chk("midpress_reached", (n < 100), 1);
    end
    chk("midpress_pb_before", (pb_out != 20'd0), 1);
    rst = 1'b0;
    #1;
    chk("midrst_pb", pb_out, 0);
    chk("midrst_count", count, 0);
    chk("midrst_busy", busy, 0);
    u_q.delete();
    rxready = 1'b0;
    rxdata = 8'h00;
    model_reset();
    clear_obs();
    @(negedge clk);
    rst = 1'b1;
    repeat (30) tick();
    chk("no_stale_keys", got_keys.size() + on_len, 0);

    // randomized traffic against the slot model
    do_reset();
    rnd_mode = 1'b1;
    repeat (1500) tick();
    rnd_mode = 1'b0;
    run_idle(600);
    check_keys("rnd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
